regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters:
  - s0: the main datapath writeback, which carries the optional jump-and-link side effect.
  - s1: the late/long-latency unit writeback.
- Each requester uses a valid/ready handshake. Arbitration is fixed-priority with anti-starvation.
- A link request is sequenced as two write beats: r31 = pc+4 first, then the rd/rt write.
- All write-port outputs are registered and drive the register file's write enable, address and data directly.

Parameters:
- STARVE_LIMIT, 4: consecutive lost arbitrations by s1 before s1 is forced to win; legal range 1..15.

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- s0_valid, in, 1: s0 write request pending.
- s0_ready, out, 1: s0 request accepted this cycle (combinational).
- s0_addr, in, 5: s0 destination register.
- s0_data, in, 32: s0 write data.
- s0_link, in, 1: s0 request also writes r31 = s0_pc+4.
- s0_pc, in, 32: PC of the linking instruction.
- s1_valid, in, 1: s1 write request pending.
- s1_ready, out, 1: s1 request accepted this cycle (combinational).
- s1_addr, in, 5: s1 destination register.
- s1_data, in, 32: s1 write data.
- wr_en, out, 1: register-file write enable (registered).
- wr_addr, out, 5: register-file write address (registered).
- wr_data, out, 32: register-file write data (registered).
- busy, out, 1: high while a link second beat is pending or wr_en=1.

Behaviour:
- Reset (async, rst_n=0):
  - wr_en=0, wr_addr=0, wr_data=0.
  - state=IDLE, starve_cnt=0, link holding registers cleared.
  - The ready outputs are combinational and therefore go low in LINK2 only; in IDLE they follow the arbitration rule.
- Handshake: a transfer occurs when valid&&ready in the same cycle. Requesters hold addr/data/link/pc stable while valid=1 and ready=0.
- States: IDLE, LINK2.
- IDLE arbitration:
  - Only s0 valid: s0_ready=1.
  - Only s1 valid: s1_ready=1.
  - Both valid: s0 wins unless starve_cnt==STARVE_LIMIT, in which case s1 wins.
  - At most one ready is high per cycle.
- LINK2: s0_ready=0 and s1_ready=0.
- starve_cnt (4 bits), updated at every edge in IDLE:
  - s1 valid and loses: increment (saturates at STARVE_LIMIT).
  - s1 granted, or s1_valid=0: clear.
  - Held in LINK2.
- Latency: write beat appears on wr_* exactly 1 cycle after the accepting edge.
- Non-link accept (s0 with link=0, or s1), at the next edge:
  - wr_en=1, wr_addr=addr, wr_data=data.
  - State stays IDLE, so back-to-back accepts give back-to-back writes.
- s0 link accept:
  - Edge N+1: wr_en=1, wr_addr=31, wr_data=s0_pc+4 (mod 2^32 wrap). s0_addr/s0_data are captured internally and state goes to LINK2.
  - Edge N+2: wr_en=1, wr_addr=captured addr, wr_data=captured data. State returns to IDLE.
  - If s0_addr==31, the data beat lands last and overrides pc+4.
- No accept in a cycle: wr_en=0 at the next edge. wr_addr/wr_data hold their previous values.
- r0 protection:
  - Any beat whose address is 0 is driven with wr_en=0, wr_addr=0, wr_data=0. The handshake still completes.
  - A link with s0_addr==0 still performs the r31 beat and still spends LINK2.
- busy = (state==LINK2) | wr_en.
- Reset asserted in LINK2: the pending data beat is discarded, and no write is issued after reset release.
- Simultaneous s0 link and s1 valid: s0 wins (counter permitting). s1 waits a minimum of 2 cycles and its starve_cnt increments once only, since it is held in LINK2.

Test Plan:
- Reset, then s0 valid (addr=5, data=0xDEADBEEF, link=0) → s0_ready=1 that cycle; next edge wr_en=1, wr_addr=5, wr_data=0xDEADBEEF; the edge after wr_en=0.
- s0 link (addr=8, data=0x11, pc=0x00400010) → edge+1: wr r31=0x00400014; edge+2: wr r8=0x11; s0_ready/s1_ready=0 during LINK2; busy high for 2 cycles.
- s0 link with addr=31, data=0xAAAA5555, pc=0xFFFFFFFC → r31 beat data 0x00000000 (wrap), then r31 beat 0xAAAA5555 last.
- s0 and s1 both valid continuously with STARVE_LIMIT=4 → grants s0,s0,s0,s0,s1,s0,…; s1 wins exactly every 5th cycle.
- s1 write to addr=0 data=0x1234 → s1_ready=1; next edge wr_en=0, wr_addr=0, wr_data=0.
- Link accepted then rst_n pulsed low during LINK2 → outputs zero immediately; after release no r8 write appears; state IDLE, starve_cnt=0.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between the main writeback (s0, with optional
// jump-and-link) and the long-latency unit (s1) using fixed priority plus anti-starvation.
module regfile_wr_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s0_valid,
    output logic        s0_ready,
    input  logic [4:0]  s0_addr,
    input  logic [31:0] s0_data,
    input  logic        s0_link,
    input  logic [31:0] s0_pc,
    input  logic        s1_valid,
    output logic        s1_ready,
    input  logic [4:0]  s1_addr,
    input  logic [31:0] s1_data,
    output logic        wr_en,
    output logic [4:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        busy
);

    typedef enum logic {
        IDLE,
        LINK2
    } state_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    localparam logic [4:0] LINK_REG = 5'd31;

    state_e      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic [4:0]  link_addr_q, link_addr_d;
    logic [31:0] link_data_q, link_data_d;
    logic        wr_en_q, wr_en_d;
    logic [4:0]  wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;

    logic        s1_forced;
    logic        grant0;
    logic        grant1;
    logic        beat_en;
    logic [4:0]  beat_addr;
    logic [31:0] beat_data;

    assign s1_forced = (starve_q == LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            starve_q    <= 4'd0;
            link_addr_q <= 5'd0;
            link_data_q <= 32'd0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= 5'd0;
            wr_data_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            link_addr_q <= link_addr_d;
            link_data_q <= link_data_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        link_addr_d = link_addr_q;
        link_data_d = link_data_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        grant0      = 1'b0;
        grant1      = 1'b0;
        beat_en     = 1'b0;
        beat_addr   = 5'd0;
        beat_data   = 32'd0;

        case (state_q)
            IDLE: begin
                grant0 = s0_valid && !(s1_valid && s1_forced);
                grant1 = s1_valid && !grant0;

                if (grant1 || !s1_valid) begin
                    starve_d = 4'd0;
                end else if (starve_q >= LIMIT) begin
                    starve_d = LIMIT;
                end else begin
                    starve_d = starve_q + 4'd1;
                end

                // A link writes r31 first and parks the rd/rt beat for the following cycle.
                if (grant0) begin
                    beat_en = 1'b1;
                    if (s0_link) begin
                        beat_addr   = LINK_REG;
                        beat_data   = s0_pc + 32'd4;
                        link_addr_d = s0_addr;
                        link_data_d = s0_data;
                        state_d     = LINK2;
                    end else begin
                        beat_addr = s0_addr;
                        beat_data = s0_data;
                    end
                end else if (grant1) begin
                    beat_en   = 1'b1;
                    beat_addr = s1_addr;
                    beat_data = s1_data;
                end
            end

            LINK2: begin
                beat_en   = 1'b1;
                beat_addr = link_addr_q;
                beat_data = link_data_q;
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // r0 is hardwired to zero, so its beats become an all-zero no-write.
        if (beat_en) begin
            if (beat_addr == 5'd0) begin
                wr_en_d   = 1'b0;
                wr_addr_d = 5'd0;
                wr_data_d = 32'd0;
            end else begin
                wr_en_d   = 1'b1;
                wr_addr_d = beat_addr;
                wr_data_d = beat_data;
            end
        end
    end

    assign s0_ready = grant0;
    assign s1_ready = grant1;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = (state_q == LINK2) | wr_en_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: expected write beats are queued when a grant
// is expected and popped one per cycle when the registered write port should show them.
module tb_regfile_wr_arbiter;

    typedef struct packed {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s0_valid;
    logic        s0_ready;
    logic [4:0]  s0_addr;
    logic [31:0] s0_data;
    logic        s0_link;
    logic [31:0] s0_pc;
    logic        s1_valid;
    logic        s1_ready;
    logic [4:0]  s1_addr;
    logic [31:0] s1_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;

    int          total = 0;
    int          bad = 0;
    beat_t       sb[$];
    logic [4:0]  lastAddr;
    logic [31:0] lastData;

    always #5 clk = ~clk;

    regfile_wr_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s0_valid (s0_valid),
        .s0_ready (s0_ready),
        .s0_addr  (s0_addr),
        .s0_data  (s0_data),
        .s0_link  (s0_link),
        .s0_pc    (s0_pc),
        .s1_valid (s1_valid),
        .s1_ready (s1_ready),
        .s1_addr  (s1_addr),
        .s1_data  (s1_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic beat_t mk(input logic [4:0] a, input logic [31:0] d);
        beat_t b;
        if (a == 5'd0) b = '0;
        else b = {1'b1, a, d};
        return b;
    endfunction

    // Compares the registered write port against the next queued beat (or an idle hold).
    task automatic checkOutput(input string tag);
        beat_t exp;
        if (sb.size() > 0) exp = sb.pop_front();
        else exp = {1'b0, lastAddr, lastData};
        check({tag, " wr_en"}, {31'd0, wr_en}, {31'd0, exp.en});
        check({tag, " wr_addr"}, {27'd0, wr_addr}, {27'd0, exp.addr});
        check({tag, " wr_data"}, wr_data, exp.data);
        check({tag, " busy"}, {31'd0, busy}, {31'd0, exp.en | (sb.size() != 0)});
        lastAddr = exp.addr;
        lastData = exp.data;
    endtask

    task automatic applyStimulus(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                                 input logic l0, input logic [31:0] pc,
                                 input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                                 input logic e0, input logic e1, input string tag);
        @(negedge clk);
        s0_valid = v0; s0_addr = a0; s0_data = d0; s0_link = l0; s0_pc = pc;
        s1_valid = v1; s1_addr = a1; s1_data = d1;
        #1;
        check({tag, " s0_ready"}, {31'd0, s0_ready}, {31'd0, e0});
        check({tag, " s1_ready"}, {31'd0, s1_ready}, {31'd0, e1});
        if (e0) begin
            if (l0) sb.push_back({1'b1, 5'd31, pc + 32'd4});
            sb.push_back(mk(a0, d0));
        end
        if (e1) sb.push_back(mk(a1, d1));
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic idleStep(input string tag);
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, tag);
    endtask

    initial begin
        rst_n = 1'b0;
        s0_valid = 1'b0; s0_addr = 5'd0; s0_data = 32'd0; s0_link = 1'b0; s0_pc = 32'd0;
        s1_valid = 1'b0; s1_addr = 5'd0; s1_data = 32'd0;
        lastAddr = 5'd0;
        lastData = 32'd0;

        #12;
        check("reset wr_en", {31'd0, wr_en}, 32'd0);
        check("reset wr_addr", {27'd0, wr_addr}, 32'd0);
        check("reset wr_data", wr_data, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, "s0_plain");
        idleStep("s0_plain_after");

        applyStimulus(1'b1, 5'd8, 32'h11, 1'b1, 32'h00400010, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, "link8");
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 5'd21, 32'h77, 1'b0, 1'b0, "link8_l2");
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 5'd21, 32'h77, 1'b0, 1'b1, "s1_after_link");

        applyStimulus(1'b1, 5'd31, 32'hAAAA5555, 1'b1, 32'hFFFFFFFC, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, "link31");
        idleStep("link31_l2");

        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 5'd0, 32'h1234, 1'b0, 1'b1, "s1_r0");

        applyStimulus(1'b1, 5'd0, 32'h99, 1'b1, 32'h100, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, "link_r0");
        idleStep("link_r0_l2");

        applyStimulus(1'b1, 5'd9, 32'h42, 1'b1, 32'h200, 1'b1, 5'd22, 32'h55, 1'b1, 1'b0, "race_link");
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 5'd22, 32'h55, 1'b0, 1'b0, "race_l2");
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 5'd22, 32'h55, 1'b0, 1'b1, "race_s1");

        idleStep("pre_starve");
        for (int i = 0; i < 10; i++) begin
            logic g1;
            g1 = ((i % 5) == 4);
            applyStimulus(1'b1, 5'(i + 1), 32'h1000 + 32'(i), 1'b0, 32'd0,
                          1'b1, 5'd20, 32'h5000 + 32'(i), !g1, g1, "starve");
        end

        // Load the starvation counter to its limit, then reset in the middle of a link.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 5'd3, 32'h3000 + 32'(i), 1'b0, 32'd0,
                          1'b1, 5'd20, 32'h6000, 1'b1, 1'b0, "preload");
        end
        applyStimulus(1'b1, 5'd8, 32'h11, 1'b1, 32'h00400010, 1'b1, 5'd20, 32'h6000, 1'b1, 1'b0, "rst_link");
        @(negedge clk);
        s0_valid = 1'b0; s1_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_mid wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_mid wr_addr", {27'd0, wr_addr}, 32'd0);
        check("rst_mid wr_data", wr_data, 32'd0);
        check("rst_mid busy", {31'd0, busy}, 32'd0);
        sb.delete();
        lastAddr = 5'd0;
        lastData = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        idleStep("post_rst");
        idleStep("post_rst2");
        for (int i = 0; i < 5; i++) begin
            logic g1;
            g1 = (i == 4);
            applyStimulus(1'b1, 5'd7, 32'h7000 + 32'(i), 1'b0, 32'd0,
                          1'b1, 5'd25, 32'h8000, !g1, g1, "post_rst_starve");
        end
        idleStep("final_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
